// File: rtl/ram_sdp_sync.sv
// ---------------------------------------------------------------------------
// ram_sdp_sync
//   Synchronous simple dual-port RAM (one write port, one read port, one
//   clock) with a registered read, a one-cycle read-valid strobe, selectable
//   read-during-write behaviour, address range checking and a hardware
//   memory-clear sequencer that runs after reset or on request.
//
// Ports
//   Clk         in   clock, all state changes on the rising edge
//   Rst         in   synchronous active-high reset (restarts the clear)
//   Clear_Req   in   one-cycle request to re-clear the whole memory
//   Write_En    in   write strobe
//   Write_Addr  in   write address   [ADDR_WIDTH-1:0]
//   data_in     in   write data      [DATA_WIDTH-1:0]
//   Read_En     in   read strobe
//   Read_Addr   in   read address    [ADDR_WIDTH-1:0]
//   data_out    out  registered read data
//   Read_Valid  out  one-cycle strobe: data_out was updated by a read
//   Busy        out  high while the clear sequencer owns the memory
//   Addr_Err    out  one-cycle pulse: an accepted strobe was out of range
// ---------------------------------------------------------------------------
module ram_sdp_sync #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    RAM_DEPTH   = 1024,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    BYPASS      = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Clear_Req,
    input  logic                  Write_En,
    input  logic [ADDR_WIDTH-1:0] Write_Addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Read_En,
    input  logic [ADDR_WIDTH-1:0] Read_Addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  Read_Valid,
    output logic                  Busy,
    output logic                  Addr_Err
);

    // Index width of the storage array itself; addresses are range-checked
    // against RAM_DEPTH before they are ever used to index it.
    localparam int MEM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    // One extra bit so RAM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    read_valid_q, read_valid_d;
    logic                    addr_err_q, addr_err_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   mem_q [RAM_DEPTH];

    logic                    mem_we_s;
    logic [MEM_AW-1:0]       mem_waddr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;

    logic                    wr_in_range_s;
    logic                    rd_in_range_s;
    logic                    wr_ok_s;
    logic                    rd_ok_s;
    logic                    same_addr_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    assign wr_in_range_s = ({1'b0, Write_Addr} < DEPTH_EXT);
    assign rd_in_range_s = ({1'b0, Read_Addr}  < DEPTH_EXT);
    assign wr_ok_s       = Write_En & wr_in_range_s;
    assign rd_ok_s       = Read_En  & rd_in_range_s;
    assign same_addr_s   = (Write_Addr == Read_Addr);
    // Only consumed when the read address is in range.
    assign rd_word_s     = mem_q[Read_Addr[MEM_AW-1:0]];

    // Next-state, memory write port and output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        read_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = Write_Addr[MEM_AW-1:0];
        mem_wdata_s  = data_in;

        case (state_q)
            ST_CLEAR: begin
                // The sequencer owns the write port; user strobes are ignored.
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_q[MEM_AW-1:0];
                mem_wdata_s = CLEAR_VALUE;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = {ADDR_WIDTH{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_READY: begin
                // One pulse even when both ports are out of range together.
                addr_err_d = (Write_En & ~wr_in_range_s) |
                             (Read_En  & ~rd_in_range_s);

                if (wr_ok_s) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end

                if (rd_ok_s) begin
                    read_valid_d = 1'b1;
                    // Write-first forwards the incoming word on a collision;
                    // read-first returns the word stored before this edge.
                    if ((BYPASS != 0) && wr_ok_s && same_addr_s) begin
                        data_out_d = data_in;
                    end else begin
                        data_out_d = rd_word_s;
                    end
                end else begin
                    read_valid_d = 1'b0;
                end

                // This cycle's user operations are still serviced above.
                if (Clear_Req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_d = ST_READY;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= {ADDR_WIDTH{1'b0}};
            data_out_q   <= {DATA_WIDTH{1'b0}};
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
            busy_q       <= busy_d;
        end
    end

    // Storage array; contents are initialised by the clear sequencer, not Rst.
    always_ff @(posedge Clk) begin
        if (mem_we_s && !Rst) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign data_out   = data_out_q;
    assign Read_Valid = read_valid_q;
    assign Busy       = busy_q;
    assign Addr_Err   = addr_err_q;

endmodule

// File: tb/tb_ram_sdp_sync.sv
// ---------------------------------------------------------------------------
// tb_ram_sdp_sync
//   Drives two ram_sdp_sync instances (write-first and read-first) with the
//   same stimulus and compares every cycle against a behavioural model that
//   keeps the memory as a plain array and the clear sequence as a count of
//   remaining busy cycles.
// ---------------------------------------------------------------------------
module tb_ram_sdp_sync;

    localparam int          DW    = 8;
    localparam int          AW    = 5;
    localparam int          DEPTH = 20;
    localparam logic [7:0]  CV    = 8'hA5;

    logic          clk = 1'b0;
    logic          rst, clr, we, re;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] din;

    logic [DW-1:0] dout_wf, dout_rf;
    logic          rv_wf, rv_rf, busy_wf, busy_rf, err_wf, err_rf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] model_mem [DEPTH];
    int            busy_left;
    logic [DW-1:0] e_dout_wf, e_dout_rf;
    logic          e_rv, e_err;

    always #5 clk = ~clk;

    ram_sdp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
                   .CLEAR_VALUE(CV), .BYPASS(1)) u_dut_wf (
        .Clk(clk), .Rst(rst), .Clear_Req(clr),
        .Write_En(we), .Write_Addr(waddr), .data_in(din),
        .Read_En(re), .Read_Addr(raddr),
        .data_out(dout_wf), .Read_Valid(rv_wf), .Busy(busy_wf), .Addr_Err(err_wf)
    );

    ram_sdp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
                   .CLEAR_VALUE(CV), .BYPASS(0)) u_dut_rf (
        .Clk(clk), .Rst(rst), .Clear_Req(clr),
        .Write_En(we), .Write_Addr(waddr), .data_in(din),
        .Read_En(re), .Read_Addr(raddr),
        .data_out(dout_rf), .Read_Valid(rv_rf), .Busy(busy_rf), .Addr_Err(err_rf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = CV;
    endtask

    // Applies the rules to the inputs seen at one rising edge.
    task automatic model_edge();
        logic [DW-1:0] old;
        if (rst) begin
            busy_left = DEPTH;
            e_dout_wf = '0;
            e_dout_rf = '0;
            e_rv      = 1'b0;
            e_err     = 1'b0;
            fill_clear();
        end else if (busy_left > 0) begin
            busy_left--;
            e_rv  = 1'b0;
            e_err = 1'b0;
        end else begin
            e_err = (we && int'(waddr) >= DEPTH) || (re && int'(raddr) >= DEPTH);
            e_rv  = re && int'(raddr) < DEPTH;
            if (e_rv) begin
                old       = model_mem[int'(raddr)];
                e_dout_rf = old;
                e_dout_wf = (we && int'(waddr) < DEPTH && waddr == raddr) ? din : old;
            end
            if (we && int'(waddr) < DEPTH) model_mem[int'(waddr)] = din;
            if (clr) begin
                busy_left = DEPTH;
                fill_clear();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("busy_wf", busy_wf, busy_left != 0);
        check("busy_rf", busy_rf, busy_left != 0);
        check("valid_wf", rv_wf, e_rv);
        check("valid_rf", rv_rf, e_rv);
        check("adderr_wf", err_wf, e_err);
        check("adderr_rf", err_rf, e_err);
        check("dout_wf", dout_wf, e_dout_wf);
        check("dout_rf", dout_rf, e_dout_rf);
    endtask

    task automatic idle();
        rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic do_write(input int a, input int d);
        idle(); we = 1'b1; waddr = AW'(a); din = DW'(d); step();
    endtask

    task automatic do_read(input int a);
        idle(); re = 1'b1; raddr = AW'(a); step();
    endtask

    // Steps with random (ignored) strobes until Busy drops; returns step count.
    task automatic wait_ready(output int n);
        n = 0;
        while (busy_wf === 1'b1 && n < 100) begin
            idle();
            we    = 1'($urandom_range(1));
            re    = 1'($urandom_range(1));
            clr   = 1'($urandom_range(1));
            waddr = AW'($urandom);
            raddr = AW'($urandom);
            din   = DW'($urandom);
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        idle();
        waddr = '0; raddr = '0; din = '0;
        busy_left = 0;
        e_dout_wf = '0; e_dout_rf = '0; e_rv = 1'b0; e_err = 1'b0;

        // Reset and initial clear
        rst = 1'b1; step();
        check("reset_busy", busy_wf, 1'b1);
        wait_ready(n);
        check("clear_len_reset", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) do_read(a);
        idle(); step();

        // Basic write / read / hold
        do_write(5, 8'h3C);
        do_read(5);
        check("rd5", dout_wf, 8'h3C);
        idle(); step();
        check("rd5_hold", dout_wf, 8'h3C);
        check("rd5_novalid", rv_wf, 1'b0);

        // Read-during-write at address 7
        do_write(7, 8'h11);
        idle(); we = 1'b1; waddr = AW'(7); din = 8'h22; re = 1'b1; raddr = AW'(7); step();
        check("rdw_wf", dout_wf, 8'h22);
        check("rdw_rf", dout_rf, 8'h11);
        do_read(7);
        check("rdw_after_rf", dout_rf, 8'h22);

        // Out of range
        do_write(25, 8'hEE);
        check("oor_wr_err", err_wf, 1'b1);
        idle(); step();
        check("oor_err_pulse", err_wf, 1'b0);
        do_read(22);
        check("oor_rd_valid", rv_wf, 1'b0);
        check("oor_rd_hold", dout_wf, 8'h22);
        idle(); we = 1'b1; waddr = AW'(31); re = 1'b1; raddr = AW'(20); step();
        check("oor_both_err", err_wf, 1'b1);
        idle(); step();
        check("oor_both_single", err_wf, 1'b0);
        do_read(19);

        // Clear request together with a write to address 2
        idle(); clr = 1'b1; we = 1'b1; waddr = AW'(2); din = 8'h77; step();
        wait_ready(n);
        check("clear_len_req", n, DEPTH);
        do_read(2);
        check("rd2_cleared", dout_wf, CV);
        for (int a = 0; a < DEPTH; a++) do_read(a);

        // Reset in the middle of a clear sequence
        do_write(9, 8'h5A);
        idle(); clr = 1'b1; step();
        for (int i = 0; i < 8; i++) begin idle(); step(); end
        idle(); rst = 1'b1; step();
        wait_ready(n);
        check("clear_len_midrst", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) do_read(a);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            we    = 1'($urandom_range(1));
            re    = 1'($urandom_range(1));
            waddr = AW'($urandom_range(DEPTH + 3));
            raddr = ($urandom_range(3) == 0) ? waddr : AW'($urandom_range(DEPTH + 3));
            din   = DW'($urandom);
            clr   = ($urandom_range(99) == 0);
            rst   = ($urandom_range(599) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sdp_sync.md
Name: ram_sdp_sync

Overview:
- Parametrised synchronous simple dual-port RAM: one write port and one read port on a single clock.
- Replaces the earlier level-sensitive RAM with a registered read, a 1-cycle valid strobe, selectable read-during-write behaviour, address range checking and a hardware memory-clear sequencer.
- Sits between datapath producers/consumers and storage. Downstream logic qualifies data with Read_Valid and holds off traffic while Busy is high.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 11, address width in bits.
- RAM_DEPTH, 1024, number of words. Must be at most 2^ADDR_WIDTH; addresses >= RAM_DEPTH are out of range.
- CLEAR_VALUE, 0, word written to every location by the clear sequencer (DATA_WIDTH bits).
- BYPASS, 1, read-during-write to the same address: 1 returns the new data (write-first), 0 returns the old data (read-first).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Clear_Req  input  1  1-cycle request to re-clear the whole memory.
- Write_En  input  1  write strobe.
- Write_Addr  input  ADDR_WIDTH  write address.
- data_in  input  DATA_WIDTH  write data.
- Read_En  input  1  read strobe.
- Read_Addr  input  ADDR_WIDTH  read address.
- data_out  output  DATA_WIDTH  registered read data.
- Read_Valid  output  1  high for exactly one cycle when data_out is updated by an accepted read.
- Busy  output  1  high while the clear sequencer owns the memory.
- Addr_Err  output  1  1-cycle pulse when an accepted strobe carries an out-of-range address.

Behaviour:
- Reset (Rst high at an edge):
  - data_out=0, Read_Valid=0, Addr_Err=0, Busy=1.
  - FSM enters CLEAR and the clear counter is set to 0.
  - Memory contents are not reset directly; the clear sequencer overwrites them.
- FSM states: CLEAR and READY.
- CLEAR state:
  - Each cycle writes CLEAR_VALUE to Memory[cnt], then cnt increments.
  - The cycle that writes address RAM_DEPTH-1 moves the FSM to READY; Busy drops at that same edge.
  - Total time: exactly RAM_DEPTH cycles of Busy=1 after reset is released.
  - User Write_En, Read_En and Clear_Req are ignored. Read_Valid=0, Addr_Err=0, data_out holds its value.
- READY state, write:
  - Write_En=1 with Write_Addr<RAM_DEPTH sets Memory[Write_Addr]<=data_in at the edge.
- READY state, read:
  - Read_En=1 with Read_Addr<RAM_DEPTH gives data_out<=Memory[Read_Addr] and Read_Valid<=1 at the edge, so data appears 1 cycle after the strobe.
  - With Read_En=0, Read_Valid<=0 and data_out holds its last value. There is no Hi-Z output.
- Read-during-write, same address, same cycle:
  - BYPASS=1: data_out gets data_in.
  - BYPASS=0: data_out gets the previous memory word.
  - The memory is written in both cases.
- Out-of-range address (>= RAM_DEPTH) on an accepted strobe:
  - The operation is dropped: no memory write, no data_out change, Read_Valid<=0.
  - Addr_Err<=1 for one cycle. If both ports are out of range in one cycle, there is still a single pulse.
- Clear_Req while in READY:
  - User operations in that same cycle are still serviced.
  - The FSM enters CLEAR at that edge with cnt=0 and Busy goes high the next cycle.
- Rst during CLEAR restarts the sequence at cnt=0, so the full RAM_DEPTH cycles are required again.
- Counter width is ADDR_WIDTH. There is no wrap past RAM_DEPTH-1 because the FSM exits at that point.

Test Plan:
- Reset and clear (RAM_DEPTH=16, CLEAR_VALUE=8'hA5): pulse Rst for 1 cycle -> Busy high for exactly 16 cycles. Reading addresses 0..15 then returns A5 each time, with Read_Valid one cycle after each Read_En.
- Basic write/read: write 8'h3C to address 5, then Read_En at address 5 the next cycle -> data_out=3C and Read_Valid=1 one cycle later. Drop Read_En -> Read_Valid=0 and data_out stays 3C.
- Read-during-write at address 7 (old value 11, new value 22): BYPASS=1 -> data_out=22; BYPASS=0 -> data_out=11. Both then read back 22.
- Out of range (RAM_DEPTH=1000, ADDR_WIDTH=10): write to address 1010 -> single Addr_Err pulse and no memory change. Read from address 1005 -> Addr_Err pulse, Read_Valid=0 and data_out unchanged.
- Clear_Req with a write to address 2 (value 77) in the same cycle: the write lands, then the memory is cleared. Busy=1 for RAM_DEPTH cycles and a read of address 2 afterwards returns CLEAR_VALUE. Strobes issued during Busy are ignored.
- Rst asserted at clear cycle 8 of 16 -> Busy stays high for a full 16 more cycles after release, and all locations read CLEAR_VALUE.
